// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory port arbiter and its round-robin picker.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } arbState_e;

    localparam logic PORT_F = 1'b0;
    localparam logic PORT_D = 1'b1;

    // Wide enough for the largest legal read latency (15).
    localparam int LAT_CNT_W = 4;

endpackage

// File: rtl/arb_rr2.sv
// Two-input round-robin picker: a lone requester wins, and on a tie the input
// not granted most recently wins. The remembered winner advances on each update strobe.
module arb_rr2
    import mem_arb_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       reqF,
    input  logic       reqD,
    input  logic       update,
    output logic [1:0] sel
);

    logic lastWinner;

    // NOTE: flops use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            lastWinner <= PORT_D;  // makes fetch win the first tie after reset
        end else if (update) begin
            lastWinner <= sel[PORT_D];
        end
    end

    // NOTE: the output gets a default before any branch so no latch can be inferred.
    always_comb begin
        sel = 2'b00;
        if (reqF && reqD) begin
            sel[PORT_F] = (lastWinner == PORT_D);
            sel[PORT_D] = (lastWinner == PORT_F);
        end else begin
            sel[PORT_F] = reqF;
            sel[PORT_D] = reqD;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares a single-ported data memory between instruction fetch and load/store.
// One transaction at a time; read data returns to the winning port MEM_LAT cycles after the strobe.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 2
)(
    input  logic              clk,
    input  logic              rst,
    input  logic              f_req,
    input  logic [ADDR_W-1:0] f_addr,
    output logic              f_gnt,
    output logic              f_rvalid,
    output logic [DATA_W-1:0] f_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              m_re,
    output logic              m_we,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    input  logic [DATA_W-1:0] m_rdata
);

    arbState_e            state;
    arbState_e            nextState;
    logic [1:0]           pick;
    logic                 startTxn;
    logic                 lastWait;
    logic                 portId;
    logic                 weQ;
    logic [ADDR_W-1:0]    addrQ;
    logic [DATA_W-1:0]    wdataQ;
    logic [DATA_W-1:0]    fRdataQ;
    logic [DATA_W-1:0]    dRdataQ;
    logic [LAT_CNT_W-1:0] latCnt;

    // Requests only count while idle; the picker's pointer moves on every grant decision.
    assign startTxn = (state == IDLE) && (|pick);
    assign lastWait = (state == WAIT) && (latCnt == LAT_CNT_W'(1));

    arb_rr2 uArb (
        .clk    (clk),
        .rst    (rst),
        .reqF   (f_req),
        .reqD   (d_req),
        .update (startTxn),
        .sel    (pick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState = state;
        case (state)
            IDLE:    if (|pick) nextState = ISSUE;
            ISSUE:   nextState = weQ ? IDLE : WAIT;
            WAIT:    if (lastWait) nextState = RESP;
            RESP:    nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    // The winner's request is latched so the memory bus is driven from flops only.
    always_ff @(posedge clk) begin
        if (rst) begin
            portId <= PORT_F;
            weQ    <= 1'b0;
            addrQ  <= '0;
            wdataQ <= '0;
        end else if (startTxn) begin
            portId <= pick[PORT_D];
            weQ    <= pick[PORT_D] & d_we;
            addrQ  <= pick[PORT_D] ? d_addr : f_addr;
            wdataQ <= (pick[PORT_D] && d_we) ? d_wdata : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            latCnt <= '0;
        end else if (state == ISSUE) begin
            latCnt <= LAT_CNT_W'(MEM_LAT);
        end else if (state == WAIT) begin
            latCnt <= latCnt - LAT_CNT_W'(1);
        end
    end

    // NOTE: the read-data registers are reset too, because both rdata outputs must read 0 after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            fRdataQ <= '0;
            dRdataQ <= '0;
        end else if (lastWait) begin
            if (portId == PORT_F) begin
                fRdataQ <= m_rdata;
            end else begin
                dRdataQ <= m_rdata;
            end
        end
    end

    always_comb begin
        f_gnt    = 1'b0;
        d_gnt    = 1'b0;
        f_rvalid = 1'b0;
        d_rvalid = 1'b0;
        m_re     = 1'b0;
        m_we     = 1'b0;
        case (state)
            ISSUE: begin
                f_gnt = (portId == PORT_F);
                d_gnt = (portId == PORT_D);
                m_re  = ~weQ;
                m_we  = weQ;
            end
            RESP: begin
                f_rvalid = (portId == PORT_F);
                d_rvalid = (portId == PORT_D);
            end
            default: ;
        endcase
    end

    assign m_addr  = addrQ;
    assign m_wdata = wdataQ;
    assign f_rdata = fRdataQ;
    assign d_rdata = dRdataQ;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: three instances (MEM_LAT 2, 1, 15), each with a latency memory model,
// a transaction-level reference model feeding expected queues, and a monitor that pops them.
module tb_mem_port_arbiter;

    typedef struct {
        bit          port;    // 0 = fetch, 1 = data
        bit          we;
        logic [7:0]  addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          gntCyc;
        int          rspCyc;
    } txn_t;

    typedef struct {
        int          due;
        logic [31:0] data;
    } rd_t;

    logic clk;
    int   cyc;
    int   vectors = 0;
    int   miscompares = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input int inst, input string name, input logic [127:0] act, input logic [127:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL inst%0d %s @cycle %0d: got %0h, expected %0h", inst, name, cyc, act, exp);
        end
    endtask

    task automatic flag(input int inst, input string name);
        vectors++;
        miscompares++;
        $display("FAIL inst%0d %s @cycle %0d", inst, name, cyc);
    endtask

    for (genvar gi = 0; gi < 3; gi++) begin : g_inst
        localparam int LAT = (gi == 0) ? 2 : ((gi == 1) ? 1 : 15);

        logic        rst, f_req, f_gnt, f_rvalid, d_req, d_we, d_gnt, d_rvalid, m_re, m_we;
        logic [7:0]  f_addr, d_addr, m_addr;
        logic [31:0] f_rdata, d_wdata, d_rdata, m_wdata, m_rdata;
        bit          done;

        mem_port_arbiter #(.ADDR_W(8), .DATA_W(32), .MEM_LAT(LAT)) dut (
            .clk      (clk),
            .rst      (rst),
            .f_req    (f_req),
            .f_addr   (f_addr),
            .f_gnt    (f_gnt),
            .f_rvalid (f_rvalid),
            .f_rdata  (f_rdata),
            .d_req    (d_req),
            .d_we     (d_we),
            .d_addr   (d_addr),
            .d_wdata  (d_wdata),
            .d_gnt    (d_gnt),
            .d_rvalid (d_rvalid),
            .d_rdata  (d_rdata),
            .m_re     (m_re),
            .m_we     (m_we),
            .m_addr   (m_addr),
            .m_wdata  (m_wdata),
            .m_rdata  (m_rdata)
        );

        logic [31:0] mem [256];
        logic [31:0] shadow [256];
        rd_t         rdq[$];
        txn_t        expGnt[$];
        txn_t        expResp[$];
        bit          memInit = 0;
        bit          rstLast = 1;
        bit          lastPort = 1;
        int          readyCyc = 0;
        logic [31:0] holdF = '0;
        logic [31:0] holdD = '0;

        task automatic tick(input int n);
            repeat (n) @(posedge clk);
            #1;
        endtask

        // Memory model, monitor and reference model share one process so their order is fixed.
        always @(negedge clk) begin : scoreboard
            txn_t e;
            rd_t  r;
            if (!memInit) begin
                for (int i = 0; i < 256; i++) mem[i] = $urandom;
                mem[8'h10] = 32'hDEADBEEF;
                shadow = mem;
                memInit = 1;
            end

            if (m_we === 1'b1) mem[m_addr] = m_wdata;
            if (m_re === 1'b1) rdq.push_back('{due: cyc + LAT, data: mem[m_addr]});
            while (rdq.size() != 0 && rdq[0].due < cyc) void'(rdq.pop_front());
            if (rdq.size() != 0 && rdq[0].due == cyc) begin
                r = rdq.pop_front();
                m_rdata = r.data;
            end else begin
                m_rdata = $urandom;
            end

            if (cyc >= 1) begin
                if (rstLast) begin
                    check(gi, "reset_pulses", {f_gnt, d_gnt, f_rvalid, d_rvalid, m_re, m_we}, '0);
                    check(gi, "reset_m_bus", {m_addr, m_wdata}, '0);
                    check(gi, "reset_rdata", {f_rdata, d_rdata}, '0);
                end
                check(gi, "re_we_exclusive", m_re & m_we, '0);

                while (expGnt.size() != 0 && expGnt[0].gntCyc < cyc) begin
                    flag(gi, "gnt_missing");
                    void'(expGnt.pop_front());
                end
                if (f_gnt || d_gnt || m_re || m_we) begin
                    if (expGnt.size() == 0) begin
                        flag(gi, "gnt_or_strobe_unexpected");
                    end else begin
                        e = expGnt.pop_front();
                        check(gi, "gnt_cycle", cyc, e.gntCyc);
                        check(gi, "gnt_port", {f_gnt, d_gnt}, e.port ? 2'b01 : 2'b10);
                        check(gi, "strobe_kind", {m_re, m_we}, e.we ? 2'b01 : 2'b10);
                        check(gi, "m_addr", m_addr, e.addr);
                        if (e.we) check(gi, "m_wdata", m_wdata, e.wdata);
                    end
                end

                while (expResp.size() != 0 && expResp[0].rspCyc < cyc) begin
                    flag(gi, "rvalid_missing");
                    void'(expResp.pop_front());
                end
                if (f_rvalid || d_rvalid) begin
                    if (expResp.size() == 0) begin
                        flag(gi, "rvalid_unexpected");
                    end else begin
                        e = expResp.pop_front();
                        check(gi, "rvalid_cycle", cyc, e.rspCyc);
                        check(gi, "rvalid_port", {f_rvalid, d_rvalid}, e.port ? 2'b01 : 2'b10);
                        check(gi, "rdata", e.port ? d_rdata : f_rdata, e.rdata);
                        if (e.port) holdD = e.rdata;
                        else        holdF = e.rdata;
                    end
                end
                check(gi, "f_rdata_hold", f_rdata, holdF);
                check(gi, "d_rdata_hold", d_rdata, holdD);

                // Reference model: one transaction at a time, timing from the latency rules.
                if (rst) begin
                    readyCyc = cyc + 1;
                    lastPort = 1'b1;
                    expGnt.delete();
                    expResp.delete();
                    holdF = '0;
                    holdD = '0;
                end else if (cyc >= readyCyc && (f_req || d_req)) begin
                    bit win;
                    win      = (f_req && d_req) ? ~lastPort : d_req;
                    lastPort = win;
                    e.port   = win;
                    e.we     = win && d_we;
                    e.addr   = win ? d_addr : f_addr;
                    e.wdata  = d_wdata;
                    e.gntCyc = cyc + 1;
                    e.rdata  = '0;
                    e.rspCyc = 0;
                    if (e.we) begin
                        shadow[e.addr] = d_wdata;
                        readyCyc = cyc + 2;
                    end else begin
                        e.rdata  = shadow[e.addr];
                        e.rspCyc = cyc + LAT + 2;
                        readyCyc = cyc + LAT + 3;
                        expResp.push_back(e);
                    end
                    expGnt.push_back(e);
                end
            end
            rstLast = rst;
        end

        initial begin : stim
            bit fg, dg;
            rst = 1; f_req = 0; f_addr = '0; d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0;
            tick(2);
            rst = 0;
            f_req = 1; f_addr = 8'h10;        // single fetch read of 0xDEADBEEF
            tick(2);
            f_req = 0;
            if (gi == 0) begin
                tick(1);
                d_req = 1; d_we = 0; d_addr = 8'h05;   // raised during WAIT, then abandoned
                tick(1);
                d_req = 0;
                tick(1);
                d_req = 1; d_we = 1; d_addr = 8'h20; d_wdata = 32'h12345678;
                tick(2);
                d_req = 0; d_we = 0;
                f_req = 1; f_addr = 8'h20;     // read back the write
                tick(2);
                f_req = 0;
                tick(3);
                f_req = 1; f_addr = 8'h30;     // read interrupted by reset in WAIT
                tick(2);
                f_req = 0; rst = 1;
                tick(1);
                rst = 0;
                f_req = 1; f_addr = 8'h11; d_req = 1; d_we = 0; d_addr = 8'h22;
                tick(30);
                f_req = 0; d_req = 0;
                tick(2);
            end else begin
                tick(LAT + 3);
            end

            for (int c = 0; c < 1500; c++) begin
                @(negedge clk);
                fg = f_gnt;
                dg = d_gnt;
                @(posedge clk);
                #1;
                if (f_req && !fg) begin
                    if ($urandom_range(0, 39) == 0) f_req = 0;
                end else if ($urandom_range(0, 2) == 0) begin
                    f_req = 1; f_addr = 8'($urandom_range(0, 15));
                end else begin
                    f_req = 0;
                end
                if (d_req && !dg) begin
                    if ($urandom_range(0, 39) == 0) d_req = 0;
                end else if ($urandom_range(0, 2) == 0) begin
                    d_req = 1; d_we = 1'($urandom_range(0, 1));
                    d_addr = 8'($urandom_range(0, 15)); d_wdata = $urandom;
                end else begin
                    d_req = 0;
                end
            end
            f_req = 0; d_req = 0;
            tick(25);
            done = 1;
        end
    end

    initial begin
        for (int c = 0; c < 20000; c++) begin
            @(posedge clk);
            if (g_inst[0].done && g_inst[1].done && g_inst[2].done) break;
        end
        if (!(g_inst[0].done && g_inst[1].done && g_inst[2].done)) begin
            vectors++;
            miscompares++;
            $display("FAIL timeout: stimulus not complete within 20000 cycles");
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the processor's single-ported data memory between the instruction-fetch path and the load/store path. Requests from each port are arbitrated round-robin and issued to memory as one-cycle read or write strobes. For reads, the arbiter counts out the fixed memory latency and returns the data to the winning port. It sits between the main control unit's fetch and memory-access sequencing and the memory's read/write enables.

## Interface
- ADDR_W, 8, address width
- DATA_W, 32, data width
- MEM_LAT, 2, cycles from memory read strobe to valid read data; legal range 1..15

- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- f_req  in  1  fetch read request; hold with f_addr stable until f_gnt
- f_addr  in  ADDR_W  fetch address
- f_gnt  out  1  one-cycle pulse: fetch request accepted
- f_rvalid  out  1  one-cycle pulse: f_rdata valid
- f_rdata  out  DATA_W  fetch read data
- d_req  in  1  data request; hold with d_we/d_addr/d_wdata stable until d_gnt
- d_we  in  1  1 = write, 0 = read
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  write data
- d_gnt  out  1  one-cycle pulse: data request accepted
- d_rvalid  out  1  one-cycle pulse: d_rdata valid (reads only)
- d_rdata  out  DATA_W  data read data
- m_re  out  1  memory read strobe
- m_we  out  1  memory write strobe
- m_addr  out  ADDR_W  memory address
- m_wdata  out  DATA_W  memory write data
- m_rdata  in  DATA_W  memory read data, valid MEM_LAT cycles after the m_re cycle

## Operation
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE: requests are sampled only in this state.
  - If any req is high, pick a winner, latch its address/wdata/we and a port id, and go to ISSUE.
  - Otherwise stay in IDLE.
- Arbitration:
  - A single requester always wins.
  - If both request, the winner is the port not granted most recently.
  - The pointer updates on every grant.
  - After reset, fetch wins the first tie.
- ISSUE (1 cycle):
  - Pulse the winner's gnt.
  - Drive m_addr, and m_wdata for writes.
  - Assert m_re (read) or m_we (write).
  - Write: go to IDLE. Read: go to WAIT and load the latency counter with MEM_LAT.
- WAIT: lasts MEM_LAT cycles. In the last WAIT cycle, capture m_rdata into the winner's rdata register, then go to RESP.
- RESP (1 cycle): pulse the winner's rvalid, then go to IDLE.
- rdata registers hold their value until the next capture for the same port.
- Fetch is read-only. No write path exists for the fetch port.
- A requester may drop req before it is granted. That request is lost, with no error.
- Only one transaction is outstanding at a time. Transactions never overlap.
- Reset values:
  - state IDLE, all gnt/rvalid low, m_re/m_we low.
  - m_addr, m_wdata, f_rdata and d_rdata are 0.
  - Round-robin pointer favours fetch.
- rst mid-transaction: return to IDLE on the next edge. The outstanding read is discarded and no rvalid is issued.

## Timing
- req high in IDLE at cycle t: gnt and the memory strobe occur at t+1.
- Read: memory data is captured at the end of cycle t+1+MEM_LAT. rvalid occurs at t+MEM_LAT+2. IDLE is reached at t+MEM_LAT+3.
- Write: IDLE at t+2. The next grant is possible at t+3.
- Throughput: one write per 2 cycles; one read per MEM_LAT+3 cycles.
- All outputs are registered. There is no combinational path from req to gnt or from req to any m_* output.
- m_re and m_we are never high in the same cycle. Each is high for exactly one cycle per transaction.

## Structure
- Package mem_arb_pkg holds:
  - the state enum (IDLE, ISSUE, WAIT, RESP)
  - port id constants (PORT_F = 0, PORT_D = 1)
  - the latency-counter width (4)
- Sub-module arb_rr2: two-input round-robin picker. It takes both req inputs and an update strobe, holds the last-winner flip-flop, and outputs a one-hot grant select.
- Top level holds the FSM, the request latches, the latency counter and the rdata registers.

## Test plan
- MEM_LAT=2, f_req at cycle 1 with f_addr=0x10; memory returns 0xDEADBEEF at cycle 4 -> f_gnt and m_re at cycle 2 with m_addr=0x10; f_rvalid at cycle 5 with f_rdata=0xDEADBEEF; next grant no earlier than cycle 7.
- d_req, d_we=1, d_addr=0x20, d_wdata=0x12345678 -> d_gnt and m_we high for one cycle with those values; m_re stays low; no d_rvalid; IDLE 2 cycles after the request.
- f_req and d_req held high continuously after reset -> grants alternate F, D, F, D, and never twice in a row to one port.
- d_req high for one cycle, dropped while a fetch is in WAIT -> no d_gnt; the fetch completes normally.
- rst asserted during WAIT of a read -> no rvalid afterwards; all outputs 0 the cycle after the reset edge; the next tie goes to fetch.
- MEM_LAT=1 and MEM_LAT=15, single read each -> rvalid exactly MEM_LAT+2 cycles after req, with the correct captured data.
